// File: rtl/io_pkg.sv
// Shared types and constants for the CPU-facing interrupt source.
package io_pkg;

  // Interrupt-source controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2,
    HALTED   = 2'd3
  } io_state_e;

  // out_port value the CPU ISR writes to acknowledge the presented byte.
  localparam logic [7:0] ACK_CODE_DEFAULT = 8'hFF;

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO, DEPTH x 8, with a combinational head (8'h00 when empty).
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow; pointers wrap naturally (DEPTH is a power of two).
  assign do_push = push && (cnt != FULL_CNT);
  assign do_pop  = pop && (cnt != '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign head    = (cnt != '0) ? mem[rd_ptr] : 8'h00;

  // Storage array: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_intr_source.sv
// Device-side byte source for the CPU: buffers bytes, presents the head on
// in_port, pulses intr per attempt, waits for the ISR ack on out_port, and
// forwards ordinary out_port writes as a byte stream.
// Handshake: a source byte transfers on a rising clk edge where
// src_valid && src_ready; src_data must be stable while src_valid is high.
module io_intr_source
  import io_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ACK_CODE  = ACK_CODE_DEFAULT,
  parameter int         PULSE_LEN = 2,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] in_port,
  output logic       intr,
  input  logic [7:0] out_port,
  input  logic       HLT_flag,
  output logic [7:0] snk_data,
  output logic       snk_valid,
  output logic [7:0] retry_cnt,
  output logic       busy,
  output io_state_e  state_dbg
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN);
  localparam logic [TW-1:0] TO_INIT    = TW'(TIMEOUT);

  io_state_e               state_q, state_d;
  logic [PW-1:0]           pulse_q, pulse_d;
  logic [TW-1:0]           to_q, to_d;
  logic [7:0]              out_prev;
  logic                    ack;
  logic                    retry_inc;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic [7:0]              fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;

  io_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (src_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Ack is the rising edge of out_port onto ACK_CODE, so one ISR write = one ack.
  assign ack       = (out_port == ACK_CODE) && (out_prev != ACK_CODE);
  assign src_ready = !fifo_full && (state_q != HALTED);
  assign fifo_push = src_valid && src_ready;
  assign intr      = (state_q == ASSERT);
  assign busy      = (state_q == ASSERT) || (state_q == WAIT_ACK);
  assign state_dbg = state_q;

  // Next-state logic: halt beats ack, ack beats timeout, HALTED is sticky.
  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    to_d      = to_q;
    fifo_pop  = 1'b0;
    retry_inc = 1'b0;
    if (HLT_flag) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_count != '0) begin
            state_d = ASSERT;
            pulse_d = PULSE_INIT;
          end
        end
        ASSERT: begin
          if (ack) begin
            fifo_pop = 1'b1;
            state_d  = IDLE;
          end else if (pulse_q == PW'(1)) begin
            state_d = WAIT_ACK;
            to_d    = TO_INIT;
          end else begin
            pulse_d = pulse_q - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            fifo_pop = 1'b1;
            state_d  = IDLE;
          end else if (to_q == TW'(1)) begin
            retry_inc = 1'b1;
            state_d   = ASSERT;
            pulse_d   = PULSE_INIT;
          end else begin
            to_d = to_q - 1'b1;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller registers, saturating retry counter and registered head byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pulse_q   <= '0;
      to_q      <= '0;
      retry_cnt <= 8'h00;
      in_port   <= 8'h00;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      to_q    <= to_d;
      if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'h01;
      in_port <= fifo_head;
    end
  end

  // Sink path: forward each changed, non-ack out_port value as a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_prev  <= 8'h00;
      snk_data  <= 8'h00;
      snk_valid <= 1'b0;
    end else begin
      out_prev  <= out_port;
      snk_valid <= (out_port != out_prev) && (out_port != ACK_CODE);
      if ((out_port != out_prev) && (out_port != ACK_CODE)) snk_data <= out_port;
    end
  end

endmodule

// File: doc/io_intr_source.md
Name: io_intr_source

Overview:
- Device-side counterpart of the CPU port/interrupt block. It sits outside the CPU and drives the CPU's in_port and intr pins.
- Buffers bytes from an external source in a small FIFO and presents the head byte on in_port. It raises an interrupt pulse per byte and waits for the CPU's ISR to acknowledge through out_port.
- Also forwards ordinary CPU out_port writes as a byte stream, and goes quiet when the CPU halts.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- ACK_CODE, 8'hFF, out_port value that acknowledges the current byte.
- PULSE_LEN, 2, cycles intr is held high per attempt (>=1).
- TIMEOUT, 64, cycles waited for ack after a pulse before re-pulsing (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_data  in  8  byte from external device.
- src_valid  in  1  src_data valid.
- src_ready  out  1  FIFO can accept; transfer occurs when src_valid && src_ready at a clock edge.
- in_port  out  8  to CPU in_port: FIFO head, or 8'h00 when empty.
- intr  out  1  to CPU intr.
- out_port  in  8  from CPU out_port.
- HLT_flag  in  1  from CPU; once 1, stays 1 until CPU reset.
- snk_data  out  8  captured CPU output byte.
- snk_valid  out  1  one-cycle strobe, snk_data valid.
- retry_cnt  out  8  saturating count of re-pulses.
- busy  out  1  high in ASSERT or WAIT_ACK.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers and count 0, state IDLE.
  - Outputs: intr=0, in_port=8'h00, snk_data=8'h00, snk_valid=0, retry_cnt=0, busy=0, src_ready=1.
  - Internal: out_prev=8'h00, pulse and timeout counters 0.
  - Reset mid-transaction discards all FIFO content.
- FIFO:
  - src_ready = (count != DEPTH) && state != HALTED.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - When full, src_ready=0 for that cycle even if a pop occurs in the same cycle.
- in_port is registered from the head entry.
  - It changes only after a pop, or on the push into an empty FIFO (visible the cycle after the push).
  - It is stable throughout ASSERT and WAIT_ACK.
- Ack detection:
  - ack = (out_port == ACK_CODE) && (out_prev != ACK_CODE); out_prev is out_port registered each cycle.
  - The ISR must write ACK_CODE once; the next ack needs an intervening non-ACK_CODE write.
- Sink path: if out_port != out_prev and out_port != ACK_CODE, then snk_data <= out_port and snk_valid=1 for one cycle (registered, 1-cycle latency). Writing the same value twice produces no strobe.
- State machine:
  - IDLE: when count!=0 and !HLT_flag, go to ASSERT with the pulse counter loaded to PULSE_LEN.
  - ASSERT: intr=1. Decrement the pulse counter; at 1, go to WAIT_ACK with the timeout counter loaded to TIMEOUT. An ack seen in ASSERT pops and goes to IDLE with intr=0 the next cycle.
  - WAIT_ACK: intr=0.
    - On ack: pop the head and go to IDLE. The next byte's pulse starts no earlier than 1 cycle later, so intr always has at least one low cycle between attempts.
    - On timeout expiry: retry_cnt++ (saturating at 8'hFF) and go to ASSERT.
  - HALTED: entered from any state whenever HLT_flag=1 (priority over ack and timeout).
    - intr=0, src_ready=0, busy=0. FIFO contents are held and snk path stays active.
    - Exits only by reset.
- Simultaneous events:
  - ack in the same cycle as timeout expiry: ack wins, no retry.
  - ack while in IDLE: ignored; no pop.

Decomposition:
- Shared package io_pkg: state enum (IDLE, ASSERT, WAIT_ACK, HALTED) and default ACK_CODE constant.
- Sub-module: io_byte_fifo (parameterised DEPTH x 8, push/pop/count/head). The FSM, ack detect and sink capture stay in the top level.

Test Plan:
- Single byte: push 8'hA5 → in_port=8'hA5, intr high for exactly 2 cycles. CPU writes 8'h00 then 8'hFF → byte popped, in_port=8'h00, busy=0, count=0.
- Retry: push 8'h3C, no ack for TIMEOUT=64 cycles → second intr pulse 66 cycles after the first, retry_cnt=1. Ack then pops the byte.
- Full/back-pressure: push 5 bytes 01..05 with no ack → src_ready=0 after 4 accepted. Four ack cycles (separated by 8'h00 writes) deliver 01,02,03,04 in order; byte 05 is pushed after the first pop.
- Sink: out_port sequence 11,11,22,FF,22 → snk_valid strobes with 11, 22, 22. No strobe for the repeated 11; FF is consumed as an ack (ignored if IDLE).
- Halt: HLT_flag=1 during WAIT_ACK with 2 bytes queued → intr stays 0 and src_ready=0 forever. rst pulse returns all outputs to reset values.
- Collision: ack arriving on the same cycle the timeout expires → pop occurs, retry_cnt unchanged.
